// File: rtl/mul_shift.sv
// Sequential shift-add multiplier: 32-bit signed x 16-bit unsigned -> 32-bit signed product + overflow.
// Define MUL_SHIFT_SAT_EN to saturate the product on overflow; otherwise it wraps to the low 32 bits.
module mul_shift (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] multiplicand,
  input  logic [15:0] multiplier,
  output logic [31:0] product,
  output logic        busy,
  output logic        done,
  output logic        ovf
);

  typedef enum logic {IDLE, CALC} state_t;

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] mreg_q, mreg_d;
  logic [31:0] mag_q, mag_d;
  logic        neg_q, neg_d;
  logic [47:0] acc_q, acc_d;
  logic [31:0] product_q, product_d;
  logic        ovf_q, ovf_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;

  logic [47:0] full;
  logic        full_ovf;
  logic [31:0] full_prod;

  // The magnitude accumulates unsigned; sign is applied once at finalize.
  // Overflow means bits [47:31] are not a pure sign extension.
  always_comb begin
    full     = neg_q ? (48'd0 - acc_q) : acc_q;
    full_ovf = !((full[47:31] == '0) || (full[47:31] == '1));
`ifdef MUL_SHIFT_SAT_EN
    if (full_ovf) full_prod = full[47] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else          full_prod = full[31:0];
`else
    full_prod = full[31:0];
`endif
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mreg_d    = mreg_q;
    mag_d     = mag_q;
    neg_d     = neg_q;
    acc_d     = acc_q;
    product_d = product_q;
    ovf_d     = ovf_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          mag_d   = multiplicand[31] ? (32'd0 - multiplicand) : multiplicand;
          mreg_d  = multiplier;
          neg_d   = multiplicand[31];
          acc_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (!cnt_q[4]) begin
          if (mreg_q[0]) acc_d = acc_q + ({16'd0, mag_q} << cnt_q[3:0]);
          mreg_d = mreg_q >> 1;
          cnt_d  = cnt_q + 5'd1;
        end else begin
          product_d = full_prod;
          ovf_d     = full_ovf;
          done_d    = 1'b1;
          busy_d    = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      mreg_q    <= '0;
      mag_q     <= '0;
      neg_q     <= 1'b0;
      acc_q     <= '0;
      product_q <= '0;
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mreg_q    <= mreg_d;
      mag_q     <= mag_d;
      neg_q     <= neg_d;
      acc_q     <= acc_d;
      product_q <= product_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign product = product_q;
  assign ovf     = ovf_q;
  assign done    = done_q;
  assign busy    = busy_q;

endmodule
